// File: rtl/btn_tick_conditioner_if.sv
// ---------------------------------------------------------------------------
// btn_tick_conditioner_if
//   Groups the button inputs and conditioned outputs of btn_tick_conditioner.
//   Signals:
//     i_Btn       [3:0] raw buttons, active-low ([0] left, [1] right,
//                       [2] start/stop, [3] fire)
//     o_BtnLevel  [3:0] debounced held level, active-high
//     o_BtnPress  [3:0] one-clock press pulse, active-high
//     o_Tick            one-clock game tick pulse
//   Modports:
//     master - the side that drives the buttons and consumes the outputs
//     slave  - the conditioner itself
// ---------------------------------------------------------------------------
interface btn_tick_conditioner_if;
  logic [3:0] i_Btn;
  logic [3:0] o_BtnLevel;
  logic [3:0] o_BtnPress;
  logic       o_Tick;

  modport master (
    output i_Btn,
    input  o_BtnLevel,
    input  o_BtnPress,
    input  o_Tick
  );

  modport slave (
    input  i_Btn,
    output o_BtnLevel,
    output o_BtnPress,
    output o_Tick
  );
endinterface

// File: rtl/btn_tick_conditioner.sv
// ---------------------------------------------------------------------------
// btn_tick_conditioner
//   Input stage of the game core. Synchronizes and debounces four raw
//   active-low push buttons, producing held levels and one-clock press
//   pulses, and generates the periodic game tick.
//
//   Ports:
//     i_Clk   system clock
//     i_Rst   asynchronous reset, active-low
//     btn_if  btn_tick_conditioner_if.slave (i_Btn in; o_BtnLevel,
//             o_BtnPress, o_Tick out; all outputs registered)
//
//   Parameters:
//     DEBOUNCE_CNT    consecutive stable clocks to accept a change (>=2)
//     TICK_DIV        clocks per game tick (>=2)
//     AUTOFIRE_TICKS  ticks between repeat fire pulses (>=1)
//
//   Optional feature macro: BTN_AUTOFIRE_EN
//     Defined   - while fire is held, o_BtnPress[3] repeats on every
//                 AUTOFIRE_TICKS-th game tick.
//     Undefined - fire pulses only on the accepted press edge.
// ---------------------------------------------------------------------------
module btn_tick_conditioner #(
  parameter int DEBOUNCE_CNT   = 250000,
  parameter int TICK_DIV       = 833333,
  parameter int AUTOFIRE_TICKS = 12
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  btn_tick_conditioner_if.slave       btn_if
);

  localparam int CW = $clog2(DEBOUNCE_CNT);
  localparam int TW = $clog2(TICK_DIV);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  localparam logic [TW-1:0] TCK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TCK_ONE  = TW'(1);
  localparam logic [TW-1:0] TCK_LAST = TW'(TICK_DIV - 1);

  // Reject parameter values the counters cannot represent.
  if (DEBOUNCE_CNT < 2 || TICK_DIV < 2 || AUTOFIRE_TICKS < 1) begin : g_bad_param
    $error("btn_tick_conditioner: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } btn_state_e;

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    btn_s;
  btn_state_e    state_q [4];
  btn_state_e    state_d [4];
  logic [CW-1:0] cnt_q   [4];
  logic [CW-1:0] cnt_d   [4];
  logic [3:0]    level_q, level_d;
  logic [3:0]    press_q, press_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_q, tick_d;

`ifdef BTN_AUTOFIRE_EN
  localparam int AW = $clog2(AUTOFIRE_TICKS + 1);
  localparam logic [AW-1:0] AF_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] AF_ONE  = AW'(1);
  localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_TICKS - 1);

  logic [AW-1:0] af_q, af_d;
`endif

  // Synchronized, inverted button view: 1 = pressed.
  assign btn_s = ~sync2_q;

  // Tick divider: the pulse appears on the clock after the last count.
  always_comb begin
    tick_d     = 1'b0;
    tick_cnt_d = tick_cnt_q;
    if (tick_cnt_q == TCK_LAST) begin
      tick_d     = 1'b1;
      tick_cnt_d = TCK_ZERO;
    end else begin
      tick_d     = 1'b0;
      tick_cnt_d = tick_cnt_q + TCK_ONE;
    end
  end

  // Per-button debounce FSMs plus optional fire autorepeat.
  always_comb begin
    level_d = level_q;
    press_d = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      case (state_q[k])
        ST_RELEASED: begin
          if (btn_s[k]) begin
            state_d[k] = ST_PRESS_PEND;
            cnt_d[k]   = CNT_ONE;
          end else begin
            cnt_d[k]   = CNT_ZERO;
          end
        end
        ST_PRESS_PEND: begin
          if (!btn_s[k]) begin
            state_d[k] = ST_RELEASED;   // glitch rejected
            cnt_d[k]   = CNT_ZERO;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k] = ST_PRESSED;    // counter holds at its terminal value
            level_d[k] = 1'b1;
            press_d[k] = 1'b1;
          end else begin
            cnt_d[k]   = cnt_q[k] + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!btn_s[k]) begin
            state_d[k] = ST_RELEASE_PEND;
            cnt_d[k]   = CNT_ONE;
          end else begin
            cnt_d[k]   = cnt_q[k];
          end
        end
        ST_RELEASE_PEND: begin
          if (btn_s[k]) begin
            state_d[k] = ST_PRESSED;
            cnt_d[k]   = CNT_ZERO;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k] = ST_RELEASED;   // releases never pulse
            level_d[k] = 1'b0;
          end else begin
            cnt_d[k]   = cnt_q[k] + CNT_ONE;
          end
        end
        default: begin
          state_d[k] = ST_RELEASED;
          cnt_d[k]   = CNT_ZERO;
          level_d[k] = 1'b0;
        end
      endcase
    end

`ifdef BTN_AUTOFIRE_EN
    // Counts ticks only while fire is held. Holding it at zero in the
    // two released-side states also covers the clear on PRESSED entry.
    af_d = af_q;
    if (state_q[3] == ST_PRESSED || state_q[3] == ST_RELEASE_PEND) begin
      if (tick_d) begin
        if (af_q == AF_LAST) begin
          af_d       = AF_ZERO;
          press_d[3] = 1'b1;            // coincides with this o_Tick
        end else begin
          af_d       = af_q + AF_ONE;
        end
      end else begin
        af_d = af_q;
      end
    end else begin
      af_d = AF_ZERO;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      sync1_q    <= 4'b1111;
      sync2_q    <= 4'b1111;
      level_q    <= 4'b0000;
      press_q    <= 4'b0000;
      tick_cnt_q <= TCK_ZERO;
      tick_q     <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= ST_RELEASED;
        cnt_q[k]   <= CNT_ZERO;
      end
`ifdef BTN_AUTOFIRE_EN
      af_q       <= AF_ZERO;
`endif
    end else begin
      sync1_q    <= btn_if.i_Btn;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      press_q    <= press_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
`ifdef BTN_AUTOFIRE_EN
      af_q       <= af_d;
`endif
    end
  end

  assign btn_if.o_BtnLevel = level_q;
  assign btn_if.o_BtnPress = press_q;
  assign btn_if.o_Tick     = tick_q;

endmodule
